// File: rtl/cpu_reset_seq_pkg.sv
// Shared types and constants for the Nios II soft-reset sequencer.
// Cause bit positions are fixed by software, which decodes the sticky register.
package cpu_reset_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } seq_state_e;

  localparam int CAUSE_SWI  = 0;
  localparam int CAUSE_HOST = 1;
  localparam int CAUSE_WDT  = 2;
  localparam int CAUSE_TMO  = 3;

  function automatic int cnt_width(input int tmo, input int hold, input int guard);
    int m;
    m = tmo;
    if (hold > m) m = hold;
    if (guard > m) m = guard;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cpu_reset_sequencer_if.sv
// Request, CPU handshake and status signals of the soft-reset sequencer.
// The sequencer takes the slave side; requesters, CPU and host take the master side.
interface cpu_reset_sequencer_if;

  logic       req_swi;
  logic       req_host;
  logic       req_wdt;
  logic       cpu_resettaken;
  logic       cause_clr;
  logic       cpu_resetrequest;
  logic       periph_reset;
  logic       busy;
  logic [3:0] cause;

  modport master (
    output req_swi, req_host, req_wdt, cpu_resettaken, cause_clr,
    input  cpu_resetrequest, periph_reset, busy, cause
  );

  modport slave (
    input  req_swi, req_host, req_wdt, cpu_resettaken, cause_clr,
    output cpu_resetrequest, periph_reset, busy, cause
  );

endinterface

// File: rtl/reset_req_sync.sv
// Two-flop synchroniser for an asynchronous level request, followed by a
// rising-edge detector so a held level produces exactly one trigger pulse.
module reset_req_sync (
  input  logic clock_core_sig,
  input  logic qsys_reset_n_sig,
  input  logic req_async,
  output logic req_edge
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clock_core_sig or negedge qsys_reset_n_sig) begin
    if (!qsys_reset_n_sig) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= req_async;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign req_edge = sync_q & ~prev_q;

endmodule

// File: rtl/cpu_reset_sequencer.sv
// Nios II soft-reset sequencer: arbitrates swi/host/wdt requests into one
// cpu_resetrequest/cpu_resettaken handshake plus a peripheral reset pulse.
//
//   state   | meaning
//   IDLE    | waiting for a request edge
//   REQ     | cpu_resetrequest high, waiting for cpu_resettaken or timeout
//   HOLD    | cpu_resetrequest and periph_reset high for HOLD_CYC cycles
//   RELEASE | outputs low, new edges ignored for GUARD_CYC cycles
module cpu_reset_sequencer
  import cpu_reset_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int HOLD_CYC    = 16,
  parameter int GUARD_CYC   = 64
) (
  input  logic                  clock_core_sig,
  input  logic                  qsys_reset_n_sig,
  cpu_reset_sequencer_if.slave  bus
);

  localparam int CW = cnt_width(TIMEOUT_CYC, HOLD_CYC, GUARD_CYC);

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYC);
  localparam logic [CW-1:0] GUARD_LOAD = CW'(GUARD_CYC);

  logic          swi_edge;
  logic          host_edge;
  logic          wdt_edge;
  logic          trig;

  seq_state_e    state_q;
  seq_state_e    state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tmo_set;
  logic [3:0]    cause_set;
  logic [3:0]    cause_q;
  logic [3:0]    cause_d;
  logic          resetrequest_q;
  logic          periph_reset_q;

  reset_req_sync u_sync_swi (
    .clock_core_sig   (clock_core_sig),
    .qsys_reset_n_sig (qsys_reset_n_sig),
    .req_async        (bus.req_swi),
    .req_edge         (swi_edge)
  );

  reset_req_sync u_sync_host (
    .clock_core_sig   (clock_core_sig),
    .qsys_reset_n_sig (qsys_reset_n_sig),
    .req_async        (bus.req_host),
    .req_edge         (host_edge)
  );

  // The watchdog already issues a one-cycle pulse in this clock domain.
  assign wdt_edge = bus.req_wdt;
  assign trig     = swi_edge | host_edge | wdt_edge;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = REQ;
          cnt_d   = '0;
        end
      end
      REQ: begin
        if (bus.cpu_resettaken) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end else if (cnt_q >= TMO_LAST) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
          tmo_set = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = RELEASE;
          cnt_d   = GUARD_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RELEASE: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A set in the same cycle as cause_clr wins for that bit.
  always_comb begin
    cause_set            = '0;
    cause_set[CAUSE_SWI]  = swi_edge;
    cause_set[CAUSE_HOST] = host_edge;
    cause_set[CAUSE_WDT]  = wdt_edge;
    cause_set[CAUSE_TMO]  = tmo_set;
    cause_d = (cause_q & {4{~bus.cause_clr}}) | cause_set;
  end

  always_ff @(posedge clock_core_sig or negedge qsys_reset_n_sig) begin
    if (!qsys_reset_n_sig) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      cause_q        <= '0;
      resetrequest_q <= 1'b0;
      periph_reset_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cause_q        <= cause_d;
      resetrequest_q <= (state_d == REQ) || (state_d == HOLD);
      periph_reset_q <= (state_d == HOLD);
    end
  end

  assign bus.cpu_resetrequest = resetrequest_q;
  assign bus.periph_reset     = periph_reset_q;
  assign bus.busy             = (state_q != IDLE);
  assign bus.cause            = cause_q;

endmodule

// File: tb/tb_cpu_reset_sequencer.sv
// Bench for cpu_reset_sequencer: stimulus queues the expected shape of each
// reset sequence; a negedge monitor measures every busy window and compares.
module tb_cpu_reset_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_reset_sequencer_if bus ();

  cpu_reset_sequencer #(
    .TIMEOUT_CYC (1024),
    .HOLD_CYC    (16),
    .GUARD_CYC   (64)
  ) dut (
    .clock_core_sig   (clk),
    .qsys_reset_n_sig (rst_n),
    .bus              (bus)
  );

  typedef struct {
    int         rise_cyc;
    int         req_len;
    int         hold_len;
    int         guard_len;
    logic [3:0] cause;
  } seq_exp_t;

  seq_exp_t sb_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: one record per busy window
  bit       in_seq = 1'b0;
  int       m_rise, m_req, m_hold, m_guard;
  seq_exp_t m_exp;

  always @(negedge clk) begin
    if (!in_seq && bus.busy === 1'b1) begin
      in_seq  = 1'b1;
      m_rise  = -1;
      m_req   = 0;
      m_hold  = 0;
      m_guard = 0;
    end
    if (in_seq) begin
      if (bus.busy !== 1'b1) begin
        in_seq = 1'b0;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_seq: got a sequence ending at cycle %0d expected none", cyc);
        end else begin
          m_exp = sb_q.pop_front();
          check_int("rise_cyc", m_rise, m_exp.rise_cyc);
          check_int("req_len", m_req, m_exp.req_len);
          check_int("hold_len", m_hold, m_exp.hold_len);
          check_int("guard_len", m_guard, m_exp.guard_len);
          check4("end_cause", bus.cause, m_exp.cause);
        end
      end else begin
        if (bus.cpu_resetrequest === 1'b1 && m_rise < 0) m_rise = cyc;
        if (bus.cpu_resetrequest === 1'b1 && bus.periph_reset !== 1'b1) m_req++;
        if (bus.periph_reset === 1'b1) m_hold++;
        if (bus.cpu_resetrequest !== 1'b1) m_guard++;
      end
    end
  end

  function automatic logic get_sig(input int sel);
    case (sel)
      0:       return bus.cpu_resetrequest;
      1:       return bus.periph_reset;
      default: return bus.busy;
    endcase
  endfunction

  // Checks the current value first, so a caller already on the right negedge returns at once.
  task automatic wait_sig(input int sel, input logic val, input int maxc, input string name);
    int n;
    n = 0;
    while (get_sig(sel) !== val && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (get_sig(sel) !== val) begin
      checks++;
      failures++;
      $display("FAIL wait_%s: got no change to %b within %0d cycles expected change", name, val, maxc);
    end
  endtask

  task automatic give_take();
    wait_sig(0, 1'b1, 20, "req");
    repeat (4) @(negedge clk);
    bus.cpu_resettaken = 1'b1;
    wait_sig(1, 1'b1, 5, "periph_hi");
  endtask

  task automatic finish_take();
    wait_sig(1, 1'b0, 30, "periph_lo");
    bus.cpu_resettaken = 1'b0;
  endtask

  task automatic wait_idle();
    wait_sig(2, 1'b0, 200, "idle");
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.cause_clr = 1'b1;
    @(negedge clk);
    bus.cause_clr = 1'b0;
    check4("cause_after_clr", bus.cause, 4'b0000);
  endtask

  task automatic push_exp(input int rise, input int rl, input int hl, input int gl, input logic [3:0] c);
    seq_exp_t e;
    e.rise_cyc  = rise;
    e.req_len   = rl;
    e.hold_len  = hl;
    e.guard_len = gl;
    e.cause     = c;
    sb_q.push_back(e);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish before time limit");
    $fatal(1);
  end

  int mark;

  initial begin
    bus.req_swi = 1'b0;
    bus.req_host = 1'b0;
    bus.req_wdt = 1'b0;
    bus.cpu_resettaken = 1'b0;
    bus.cause_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_int("rst_request", int'(bus.cpu_resetrequest), 0);
    check_int("rst_periph", int'(bus.periph_reset), 0);
    check_int("rst_busy", int'(bus.busy), 0);
    check4("rst_cause", bus.cause, 4'b0000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_int("idle_busy", int'(bus.busy), 0);

    // 1: swi level request, take after 5 cycles, no retrigger while held
    @(negedge clk);
    mark = cyc;
    bus.req_swi = 1'b1;
    push_exp(mark + 3, 5, 16, 64, 4'b0001);
    give_take();
    finish_take();
    wait_idle();
    repeat (20) @(negedge clk);
    bus.req_swi = 1'b0;
    pulse_clr();

    // 2: wdt pulse with no take -> full timeout
    @(negedge clk);
    mark = cyc;
    bus.req_wdt = 1'b1;
    push_exp(mark + 1, 1024, 16, 64, 4'b1100);
    @(negedge clk);
    bus.req_wdt = 1'b0;
    wait_sig(1, 1'b1, 1100, "tmo_hold");
    wait_idle();
    pulse_clr();

    // 3: host edge during HOLD of a swi sequence
    @(negedge clk);
    mark = cyc;
    bus.req_swi = 1'b1;
    push_exp(mark + 3, 5, 16, 64, 4'b0011);
    give_take();
    repeat (3) @(negedge clk);
    bus.req_host = 1'b1;
    finish_take();
    wait_idle();
    bus.req_swi = 1'b0;
    bus.req_host = 1'b0;
    repeat (5) @(negedge clk);
    pulse_clr();

    // 4: swi and wdt edges in the same cycle, then clr coinciding with wdt
    @(negedge clk);
    mark = cyc;
    bus.req_swi = 1'b1;
    push_exp(mark + 3, 5, 16, 64, 4'b0101);
    repeat (2) @(negedge clk);
    bus.req_wdt = 1'b1;
    @(negedge clk);
    bus.req_wdt = 1'b0;
    give_take();
    finish_take();
    wait_idle();
    bus.req_swi = 1'b0;
    pulse_clr();
    @(negedge clk);
    mark = cyc;
    bus.cause_clr = 1'b1;
    bus.req_wdt = 1'b1;
    push_exp(mark + 1, 5, 16, 64, 4'b0100);
    @(negedge clk);
    bus.cause_clr = 1'b0;
    bus.req_wdt = 1'b0;
    check4("clr_vs_wdt", bus.cause, 4'b0100);
    give_take();
    finish_take();
    wait_idle();
    pulse_clr();

    // 5: reset asserted mid-HOLD, then a normal host sequence
    @(negedge clk);
    mark = cyc;
    bus.req_swi = 1'b1;
    push_exp(mark + 3, 5, 6, 0, 4'b0000);
    give_take();
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_int("abort_request", int'(bus.cpu_resetrequest), 0);
    check_int("abort_periph", int'(bus.periph_reset), 0);
    check_int("abort_busy", int'(bus.busy), 0);
    check4("abort_cause", bus.cause, 4'b0000);
    bus.req_swi = 1'b0;
    bus.cpu_resettaken = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    mark = cyc;
    bus.req_host = 1'b1;
    push_exp(mark + 3, 5, 16, 64, 4'b0010);
    give_take();
    finish_take();
    wait_idle();
    bus.req_host = 1'b0;
    pulse_clr();

    // 6: one-cycle host glitch starts a sequence; host edge in RELEASE is ignored
    repeat (3) @(negedge clk);
    mark = cyc;
    #3 bus.req_host = 1'b1;
    #4 bus.req_host = 1'b0;
    push_exp(mark + 3, 5, 16, 64, 4'b0010);
    give_take();
    pulse_clr();
    finish_take();
    repeat (10) @(negedge clk);
    bus.req_host = 1'b1;
    wait_idle();
    repeat (20) @(negedge clk);
    bus.req_host = 1'b0;

    repeat (10) @(negedge clk);
    check_int("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
